// File: rtl/keypad_entry_buffer_if.sv
// Keypad entry buffer signal bundle: debounced key input, live display outputs,
// and the committed-value valid/ready handshake.
interface keypad_entry_buffer_if #(
  parameter int NUM_DIGITS = 6
);
  logic [3:0]              debouncedKey;
  logic                    debouncedValid;
  logic [4*NUM_DIGITS-1:0] disp_digits;
  logic [NUM_DIGITS-1:0]   disp_on;
  logic [3:0]              entry_count;
  logic [4*NUM_DIGITS-1:0] out_data;
  logic [3:0]              out_len;
  logic                    out_valid;
  logic                    out_ready;
  logic                    err_pulse;

  // master: key source and consumer; slave: the entry buffer itself
  modport master (
    output debouncedKey, debouncedValid, out_ready,
    input  disp_digits, disp_on, entry_count, out_data, out_len, out_valid, err_pulse
  );

  modport slave (
    input  debouncedKey, debouncedValid, out_ready,
    output disp_digits, disp_on, entry_count, out_data, out_len, out_valid, err_pulse
  );
endinterface

// File: rtl/keypad_entry_buffer.sv
// Multi-digit hex entry with backspace/enter editing; committed entries are
// offered downstream over valid/ready.
//
//  state      | meaning
//  S_ENTRY    | editing live entry; digits, backspace and enter accepted
//  S_WAIT_ACK | committed value offered; all keystrokes rejected
module keypad_entry_buffer #(
  parameter int NUM_DIGITS = 6
) (
  input  logic                  CLOCK_50,
  input  logic                  Reset,
  keypad_entry_buffer_if.slave  kif
);

  typedef enum logic {S_ENTRY, S_WAIT_ACK} state_t;

  localparam logic [3:0] KEY_BKSP  = 4'hE;
  localparam logic [3:0] KEY_ENTER = 4'hF;
  localparam logic [3:0] CAP       = 4'(NUM_DIGITS);

  state_t                  r_state,     w_state_n;
  logic                    r_last_valid;
  logic [4*NUM_DIGITS-1:0] r_digits,    w_digits_n;
  logic [NUM_DIGITS-1:0]   r_on,        w_on_n;
  logic [3:0]              r_count,     w_count_n;
  logic [4*NUM_DIGITS-1:0] r_out_data,  w_out_data_n;
  logic [3:0]              r_out_len,   w_out_len_n;
  logic                    r_out_valid, w_out_valid_n;
  logic                    r_err,       w_err_n;
  logic                    w_strobe;

  // last_valid resets high so a key held across reset release is not a press
  assign w_strobe = kif.debouncedValid & ~r_last_valid;

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      r_state      <= S_ENTRY;
      r_last_valid <= 1'b1;
      r_digits     <= '0;
      r_on         <= '0;
      r_count      <= '0;
      r_out_data   <= '0;
      r_out_len    <= '0;
      r_out_valid  <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_last_valid <= kif.debouncedValid;
      r_digits     <= w_digits_n;
      r_on         <= w_on_n;
      r_count      <= w_count_n;
      r_out_data   <= w_out_data_n;
      r_out_len    <= w_out_len_n;
      r_out_valid  <= w_out_valid_n;
      r_err        <= w_err_n;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_digits_n    = r_digits;
    w_count_n     = r_count;
    w_out_data_n  = r_out_data;
    w_out_len_n   = r_out_len;
    w_out_valid_n = r_out_valid;
    w_err_n       = 1'b0;
    w_on_n        = '0;

    case (r_state)
      S_ENTRY: begin
        if (w_strobe) begin
          if (kif.debouncedKey == KEY_BKSP) begin
            if (r_count != 4'd0) begin
              w_digits_n = r_digits >> 4;
              w_count_n  = r_count - 4'd1;
            end
          end else if (kif.debouncedKey == KEY_ENTER) begin
            if (r_count != 4'd0) begin
              w_out_data_n  = r_digits;
              w_out_len_n   = r_count;
              w_out_valid_n = 1'b1;
              w_digits_n    = '0;
              w_count_n     = 4'd0;
              w_state_n     = S_WAIT_ACK;
            end else begin
              w_err_n = 1'b1;
            end
          end else if (r_count < CAP) begin
            w_digits_n      = r_digits << 4;
            w_digits_n[3:0] = kif.debouncedKey;
            w_count_n       = r_count + 4'd1;
          end else begin
            w_err_n = 1'b1;
          end
        end
      end

      S_WAIT_ACK: begin
        if (w_strobe) w_err_n = 1'b1;
        if (r_out_valid && kif.out_ready) begin
          w_out_valid_n = 1'b0;
          w_state_n     = S_ENTRY;
        end
      end

      default: w_state_n = S_ENTRY;
    endcase

    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_on_n[i] = (i < int'(w_count_n));
    end
  end

  assign kif.disp_digits = r_digits;
  assign kif.disp_on     = r_on;
  assign kif.entry_count = r_count;
  assign kif.out_data    = r_out_data;
  assign kif.out_len     = r_out_len;
  assign kif.out_valid   = r_out_valid;
  assign kif.err_pulse   = r_err;

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Directed bench for keypad_entry_buffer: a vector table for editing, plus
// hand-written sequences for hold, commit/handshake and reset corners.
module tb_keypad_entry_buffer;
  localparam int N = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   err_cnt = 0;

  always #5 clk = ~clk;

  keypad_entry_buffer_if #(.NUM_DIGITS(N)) kif ();

  keypad_entry_buffer #(.NUM_DIGITS(N)) dut (
    .CLOCK_50 (clk),
    .Reset    (rst),
    .kif      (kif.slave)
  );

  always @(negedge clk) if (kif.err_pulse === 1'b1) err_cnt++;

  typedef struct {
    logic [3:0]  key;
    logic [23:0] exp_digits;
    logic [5:0]  exp_on;
    logic [3:0]  exp_count;
    int          exp_err;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] k, input int hold);
    @(negedge clk);
    kif.debouncedKey   = k;
    kif.debouncedValid = 1'b1;
    repeat (hold) @(negedge clk);
    kif.debouncedValid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int e0;
    kif.debouncedKey   = 4'h0;
    kif.debouncedValid = 1'b0;
    kif.out_ready      = 1'b0;

    vecs[0]  = '{4'h1, 24'h000001, 6'b000001, 4'd1, 0};
    vecs[1]  = '{4'h2, 24'h000012, 6'b000011, 4'd2, 0};
    vecs[2]  = '{4'h3, 24'h000123, 6'b000111, 4'd3, 0};
    vecs[3]  = '{4'hE, 24'h000012, 6'b000011, 4'd2, 0};
    vecs[4]  = '{4'hE, 24'h000001, 6'b000001, 4'd1, 0};
    vecs[5]  = '{4'hE, 24'h000000, 6'b000000, 4'd0, 0};
    vecs[6]  = '{4'hE, 24'h000000, 6'b000000, 4'd0, 0};
    vecs[7]  = '{4'h4, 24'h000004, 6'b000001, 4'd1, 0};
    vecs[8]  = '{4'h5, 24'h000045, 6'b000011, 4'd2, 0};
    vecs[9]  = '{4'h6, 24'h000456, 6'b000111, 4'd3, 0};
    vecs[10] = '{4'h7, 24'h004567, 6'b001111, 4'd4, 0};
    vecs[11] = '{4'h8, 24'h045678, 6'b011111, 4'd5, 0};
    vecs[12] = '{4'hD, 24'h45678D, 6'b111111, 4'd6, 0};
    vecs[13] = '{4'hA, 24'h45678D, 6'b111111, 4'd6, 1};
    vecs[14] = '{4'hE, 24'h045678, 6'b011111, 4'd5, 0};

    repeat (3) @(negedge clk);
    check("reset_digits", 32'(kif.disp_digits), 32'h0);
    check("reset_on",     32'(kif.disp_on), 32'h0);
    check("reset_count",  32'(kif.entry_count), 32'h0);
    check("reset_valid",  32'(kif.out_valid), 32'h0);
    check("reset_err",    32'(kif.err_pulse), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      e0 = err_cnt;
      press(vecs[i].key, 3);
      check($sformatf("vec%0d_digits", i), 32'(kif.disp_digits), 32'(vecs[i].exp_digits));
      check($sformatf("vec%0d_on", i),     32'(kif.disp_on), 32'(vecs[i].exp_on));
      check($sformatf("vec%0d_count", i),  32'(kif.entry_count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_err", i),    32'(err_cnt - e0), 32'(vecs[i].exp_err));
    end

    // long hold yields a single digit
    do_reset();
    press(4'h5, 50000);
    check("hold_count",  32'(kif.entry_count), 32'd1);
    check("hold_on",     32'(kif.disp_on), 32'b000001);
    check("hold_digits", 32'(kif.disp_digits), 32'h5);

    // commit with consumer stalled, reject key, then handshake
    do_reset();
    press(4'h4, 2);
    press(4'h2, 2);
    press(4'hF, 2);
    check("commit_valid", 32'(kif.out_valid), 32'd1);
    check("commit_data",  32'(kif.out_data), 32'h42);
    check("commit_len",   32'(kif.out_len), 32'd2);
    check("commit_on",    32'(kif.disp_on), 32'h0);
    check("commit_disp",  32'(kif.disp_digits), 32'h0);
    e0 = err_cnt;
    press(4'h9, 2);
    check("wait_err",   32'(err_cnt - e0), 32'd1);
    check("wait_data",  32'(kif.out_data), 32'h42);
    check("wait_valid", 32'(kif.out_valid), 32'd1);
    check("wait_count", 32'(kif.entry_count), 32'd0);
    kif.out_ready = 1'b1;
    @(negedge clk);
    check("ack_valid", 32'(kif.out_valid), 32'd0);
    check("ack_data",  32'(kif.out_data), 32'h42);
    check("ack_len",   32'(kif.out_len), 32'd2);
    kif.out_ready = 1'b0;
    press(4'h7, 2);
    check("after_ack_count", 32'(kif.entry_count), 32'd1);

    // strobe coinciding with the accepting handshake is rejected
    press(4'hF, 2);
    check("commit2_data", 32'(kif.out_data), 32'h7);
    kif.debouncedKey   = 4'h3;
    kif.debouncedValid = 1'b1;
    kif.out_ready      = 1'b1;
    @(negedge clk);
    check("same_cyc_valid", 32'(kif.out_valid), 32'd0);
    check("same_cyc_err",   32'(kif.err_pulse), 32'd1);
    kif.out_ready      = 1'b0;
    kif.debouncedValid = 1'b0;
    repeat (2) @(negedge clk);
    check("same_cyc_count", 32'(kif.entry_count), 32'd0);

    // enter on empty entry
    e0 = err_cnt;
    press(4'hF, 2);
    check("empty_enter_err",   32'(err_cnt - e0), 32'd1);
    check("empty_enter_valid", 32'(kif.out_valid), 32'd0);

    // key held across reset release is not a keystroke
    kif.debouncedKey   = 4'h3;
    kif.debouncedValid = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    e0 = err_cnt;
    repeat (4) @(negedge clk);
    check("held_rst_count", 32'(kif.entry_count), 32'd0);
    check("held_rst_err",   32'(err_cnt - e0), 32'd0);
    kif.debouncedValid = 1'b0;
    repeat (2) @(negedge clk);
    press(4'h3, 2);
    check("repress_count",  32'(kif.entry_count), 32'd1);
    check("repress_digits", 32'(kif.disp_digits), 32'h3);

    // reset in WAIT_ACK discards committed value
    press(4'hF, 2);
    check("pre_rst_valid", 32'(kif.out_valid), 32'd1);
    do_reset();
    check("rst_wait_valid", 32'(kif.out_valid), 32'd0);
    check("rst_wait_data",  32'(kif.out_data), 32'h0);
    check("rst_wait_len",   32'(kif.out_len), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
